// File: rtl/vga_pkg.sv
// Shared constants, swap FSM state type and the framebuffer offset helper
// for the VGA scan-out path.
package vga_pkg;

   localparam int unsigned H_ACT = 640;
   localparam int unsigned V_ACT = 480;
   localparam int unsigned FB_W  = 320;
   localparam int unsigned FB_H  = 240;
   localparam int unsigned FB_AW = 17;
   localparam int unsigned RGB_W = 12;

   typedef enum logic {
      SWAP_IDLE,
      SWAP_ACKED
   } swap_state_t;

   // row*320 + col built from shifts; 2x upscale drops the LSB of each coordinate
   function automatic logic [FB_AW-1:0] fb_offset(input logic [9:0] h, input logic [9:0] v);
      logic [FB_AW-1:0] row;
      logic [FB_AW-1:0] col;
      row = {8'd0, v[9:1]};
      col = {8'd0, h[9:1]};
      return (row << 8) + (row << 6) + col;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset to a programmable value.
module vga_delay_line #(
   parameter int unsigned      DEPTH     = 4,
   parameter int unsigned      WIDTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             pclk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge pclk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
         stage[0] <= d;
         for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch for a 2x-upscaled 320x240 double buffer: address stage,
// RAM data capture, delay-matched syncs and vsync-aligned buffer swap.
module vga_pixel_fetch
   import vga_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        in_hsync,
   input  logic        in_vsync,
   input  logic [9:0]  h_cnt,
   input  logic [9:0]  v_cnt,
   output logic [17:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [11:0] mem_rdata,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        hsync,
   output logic        vsync,
   input  logic        swap_req,
   output logic        swap_ack,
   output logic        front_sel,
   output logic [7:0]  frame_cnt
);

   localparam int unsigned LAT = MEM_LAT + 2;

   swap_state_t      state, state_nxt;
   logic             front_nxt;
   logic             ack_nxt;
   logic             vsync_prev;
   logic             boundary;
   logic             dly_valid;
   logic [RGB_W-1:0] rgb_q;

   always_ff @(posedge pclk) begin
      if (reset) begin
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
      end else begin
         mem_rd_en <= in_valid;
         if (in_valid) mem_addr <= {front_sel, fb_offset(h_cnt, v_cnt)};
      end
   end

   vga_delay_line #(
      .DEPTH     (LAT),
      .WIDTH     (3),
      .RESET_VAL (3'b011)
   ) u_sync_dly (
      .pclk  (pclk),
      .reset (reset),
      .d     ({in_valid, in_hsync, in_vsync}),
      .q     ({dly_valid, hsync, vsync})
   );

   // RAM data lands one cycle before the pins; blanking uses the valid that
   // travels with the syncs so colour and syncs leave on the same edge.
   always_ff @(posedge pclk) begin
      if (reset) rgb_q <= '0;
      else       rgb_q <= mem_rdata;
   end

   assign vga_r = dly_valid ? rgb_q[11:8] : '0;
   assign vga_g = dly_valid ? rgb_q[7:4]  : '0;
   assign vga_b = dly_valid ? rgb_q[3:0]  : '0;

   assign boundary = vsync_prev & ~in_vsync;

   always_comb begin
      state_nxt = state;
      front_nxt = front_sel;
      ack_nxt   = 1'b0;
      unique case (state)
         SWAP_IDLE: begin
            if (boundary && swap_req) begin
               front_nxt = ~front_sel;
               ack_nxt   = 1'b1;
               state_nxt = SWAP_ACKED;
            end
         end
         SWAP_ACKED: begin
            if (!swap_req) state_nxt = SWAP_IDLE;
         end
         default: state_nxt = SWAP_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         state      <= SWAP_IDLE;
         front_sel  <= 1'b0;
         swap_ack   <= 1'b0;
         vsync_prev <= 1'b1;
         frame_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         front_sel  <= front_nxt;
         swap_ack   <= ack_nxt;
         vsync_prev <= in_vsync;
         if (boundary) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule
